// File: rtl/backing_mem_responder_if.sv
// Request/response bus between a cache (master) and its backing memory (slave).
// Requests are single-word writes or line refill reads; responses are beat streams.
interface backing_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_last;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_data, resp_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_data, resp_last
  );
endinterface

// File: rtl/backing_mem_responder.sv
// Fixed-latency backing memory: single-word byte-strobed write-through with an ack,
// or line refill read returned as LINE_WORDS consecutive beats.
module backing_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  backing_mem_responder_if.slave  bus,
  output logic                    busy
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LW_W  = $clog2(LINE_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    WACK  = 2'd3
  } state_t;

  state_t                state_r, next_state_s;
  logic [CNT_W-1:0]      lat_cnt_r, lat_cnt_nxt_s;
  logic [LW_W-1:0]       beat_r, beat_nxt_s;
  logic [IDX_W-1:0]      idx_r;
  logic                  we_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [3:0]            wstrb_r;
  logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];
  logic                  resp_valid_r, resp_valid_nxt_s;
  logic                  resp_last_r, resp_last_nxt_s;
  logic [DATA_WIDTH-1:0] resp_data_r, resp_data_nxt_s;
  logic                  handshake_s;
  logic                  wr_commit_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  addr_unused_s;

  assign handshake_s   = (state_r == IDLE) && bus.req_valid;
  assign wr_commit_s   = (state_r == WAIT) && we_r && (lat_cnt_r == '0);
  assign rd_idx_s      = {idx_r[IDX_W-1:LW_W], beat_nxt_s};
  // Byte offset and bits above the store depth wrap away by design.
  assign addr_unused_s = ^{bus.req_addr[ADDR_WIDTH-1:IDX_W+2], bus.req_addr[1:0]};

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      lat_cnt_r <= '0;
      beat_r    <= '0;
    end else begin
      state_r   <= next_state_s;
      lat_cnt_r <= lat_cnt_nxt_s;
      beat_r    <= beat_nxt_s;
    end
  end

  // Next-state and counter update.
  always_comb begin
    next_state_s  = state_r;
    lat_cnt_nxt_s = lat_cnt_r;
    beat_nxt_s    = beat_r;
    case (state_r)
      IDLE: begin
        beat_nxt_s = '0;
        if (handshake_s) begin
          next_state_s  = WAIT;
          lat_cnt_nxt_s = CNT_W'(LATENCY - 1);
        end else begin
          lat_cnt_nxt_s = '0;
        end
      end
      WAIT: begin
        if (lat_cnt_r == '0) begin
          next_state_s = we_r ? WACK : BURST;
          beat_nxt_s   = '0;
        end else begin
          lat_cnt_nxt_s = lat_cnt_r - CNT_W'(1);
        end
      end
      BURST: begin
        if (beat_r == LW_W'(LINE_WORDS - 1)) begin
          next_state_s = IDLE;
          beat_nxt_s   = '0;
        end else begin
          beat_nxt_s = beat_r + LW_W'(1);
        end
      end
      WACK:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Response values for the cycle being entered, so outputs stay state-aligned.
  always_comb begin
    resp_valid_nxt_s = 1'b0;
    resp_last_nxt_s  = 1'b0;
    resp_data_nxt_s  = '0;
    case (next_state_s)
      BURST: begin
        resp_valid_nxt_s = 1'b1;
        resp_last_nxt_s  = (beat_nxt_s == LW_W'(LINE_WORDS - 1));
        resp_data_nxt_s  = mem_r[rd_idx_s];
      end
      WACK: begin
        resp_valid_nxt_s = 1'b1;
        resp_last_nxt_s  = 1'b1;
      end
      default: begin
        resp_valid_nxt_s = 1'b0;
        resp_last_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_r <= 1'b0;
      resp_last_r  <= 1'b0;
      resp_data_r  <= '0;
    end else begin
      resp_valid_r <= resp_valid_nxt_s;
      resp_last_r  <= resp_last_nxt_s;
      resp_data_r  <= resp_data_nxt_s;
    end
  end

  // Request capture at handshake; later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r   <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
      wstrb_r <= 4'b0000;
    end else if (handshake_s) begin
      idx_r   <= bus.req_addr[IDX_W+1:2];
      we_r    <= bus.req_we;
      wdata_r <= bus.req_wdata;
      wstrb_r <= bus.req_wstrb;
    end
  end

  // Backing store, never reset; bytes land on the final WAIT edge.
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_r[b]) begin
          mem_r[idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_last  = resp_last_r;
  assign bus.resp_data  = resp_data_r;
  assign busy           = (state_r != IDLE);
endmodule

// File: doc/backing_mem_responder.md
BACKING_MEM_RESPONDER -- requirements
Module: backing_mem_responder

Parameters
REQ-001 ADDR_WIDTH, 32, byte-address width of request address SHALL be set by this parameter.
REQ-002 DATA_WIDTH, 32, width of write data and response data SHALL be set by this parameter.
REQ-003 MEM_WORDS, 1024, backing store depth in words SHALL be set by this parameter (power of two).
REQ-004 LINE_WORDS, 4, words per refill burst SHALL be set by this parameter (power of two, >=2).
REQ-005 LATENCY, 3, wait cycles between request acceptance and first response beat SHALL be set by this parameter (>=1).

Interface
REQ-006 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-007 rst  in  1  reset SHALL be asynchronous and active-low (asserted when 0).
REQ-008 req_valid  in  1  initiator (cache) request present.
REQ-009 req_ready  out  1  responder can accept a request this cycle.
REQ-010 req_we  in  1  1 = single-word write-through, 0 = line refill read.
REQ-011 req_addr  in  ADDR_WIDTH  byte address of request.
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 req_wstrb  in  4  per-byte write enables; bit i covers wdata[8i+7:8i].
REQ-014 resp_valid  out  1  response beat valid.
REQ-015 resp_data  out  DATA_WIDTH  refill word; 0 on write acknowledge.
REQ-016 resp_last  out  1  final beat of a response.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, BURST, WACK.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake occurs when req_valid && req_ready on a rising edge.
REQ-020 On handshake, req_addr, req_we, req_wdata, req_wstrb SHALL be captured; later input changes SHALL not affect the transaction.
REQ-021 Handshake SHALL move IDLE -> WAIT and load a latency counter; WAIT SHALL last exactly LATENCY cycles.
REQ-022 Word index SHALL be req_addr[log2(MEM_WORDS)+1:2]; upper address bits ignored (wrap modulo MEM_WORDS); req_addr[1:0] ignored.
REQ-023 Read: refill base SHALL be the word index with its low log2(LINE_WORDS) bits cleared; WAIT -> BURST after LATENCY cycles.
REQ-024 BURST SHALL emit LINE_WORDS consecutive beats, one per cycle, words base+0 .. base+LINE_WORDS-1 in order, resp_valid=1 each beat; no backpressure (initiator must accept every beat).
REQ-025 resp_last SHALL be 1 only on beat LINE_WORDS-1; after that beat, BURST -> IDLE.
REQ-026 Write: in the last WAIT cycle, bytes with wstrb bit set SHALL be written; bytes with strobe 0 unchanged; WAIT -> WACK.
REQ-027 WACK SHALL last one cycle with resp_valid=1, resp_last=1, resp_data=0, then -> IDLE.
REQ-028 First-response latency SHALL be LATENCY+1 cycles after the handshake edge (read: first beat; write: ack).
REQ-029 wstrb=0000 SHALL still complete with an ack and leave memory unchanged.
REQ-030 A read accepted in the cycle after a WACK SHALL return the newly written data (no stale read).
REQ-031 req_valid outside IDLE SHALL be ignored (not queued); initiator must hold it until ready.
REQ-032 resp_valid, resp_last SHALL be 0 in IDLE and WAIT; resp_data SHALL be 0 whenever resp_valid=0.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, counters 0, resp_valid=0, resp_last=0, resp_data=0, busy=0, req_ready=1 (after release).
REQ-034 Memory contents SHALL not be cleared by reset; initial contents zero at time zero.
REQ-035 Reset during WAIT of a write SHALL abort with no memory modification; reset during BURST SHALL abort remaining beats with no resp_last.

Verification
REQ-036 Write 0xDEADBEEF to 0x40, wstrb=1111 -> ack (resp_valid=1, resp_last=1, resp_data=0) 4 cycles after handshake (LATENCY=3).
REQ-037 Preload words 0x10..0x13 = 0xA0..0xA3, read addr 0x48 -> 4 beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, resp_last only on 0xA3, first beat 4 cycles after handshake.
REQ-038 Word 0x40 = 0xDEADBEEF, write 0x00001234 with wstrb=0011 -> subsequent read returns 0xDEAD1234 at 0x40.
REQ-039 Write 0x55 to byte address 0x1000 (MEM_WORDS=1024) -> word index 0 updated (wrap).
REQ-040 Assert rst=0 in second WAIT cycle of write to 0x80 -> outputs 0 immediately, word 0x20 unchanged, req_ready=1 after release.
REQ-041 Hold req_valid=1 with new address throughout a burst -> second request accepted only on first IDLE cycle; first transaction's data unaffected.
